spi_slave_port: RTL and testbench

SPI responder (slave) pin adapter. It is the far end of the SPI master GPIO port: the master drives SCK and CS and samples DQ; this block receives them.
- SCK, CS and MOSI (dq0) pins are synchronized into the system clock domain.
- Mode-0 bytes are shifted in on MOSI and shifted out on MISO (dq1).
- Bytes are exchanged with the core through valid/ready byte interfaces.
- Used for an on-chip debug/config slave and as a bench model for the master port.

---
 rtl/spi_slave_port_pkg.sv | 14 +
 rtl/spi_slave_port_sync_bit.sv | 29 ++
 rtl/spi_slave_port.sv | 188 ++++++++++++++++++
 tb/tb_spi_slave_port.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_port_pkg.sv
// Shared defaults and types for the SPI responder pin adapter.
package spi_slave_port_pkg;

    localparam int unsigned FRAME_BITS_DEF  = 8;
    localparam int unsigned SYNC_STAGES_DEF = 3;
    localparam logic [7:0]  FILL_BYTE_DEF   = 8'hFF;
    localparam int unsigned CNT_W_DEF       = $clog2(FRAME_BITS_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/spi_slave_port_sync_bit.sv
// Pin synchronizer chain plus one history flop; reports the synced level and a change strobe.
module spi_sync_bit #(
    parameter int unsigned SYNC_STAGES = 3,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic edge_c
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   hist;

    always_ff @(posedge clock) begin
        if (reset) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            hist  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            hist  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync   = chain[SYNC_STAGES-1];
    assign edge_c = sync ^ hist;

endmodule

// File: rtl/spi_slave_port.sv
// Mode-0 SPI responder: synchronizes SCK/CS/MOSI, shifts words in and out,
// and exchanges them with the core over valid/ready byte interfaces.
module spi_slave_port
    import spi_slave_port_pkg::*;
#(
    parameter int unsigned           SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned           FRAME_BITS  = FRAME_BITS_DEF,
    parameter logic [FRAME_BITS-1:0] FILL_BYTE   = FRAME_BITS'(FILL_BYTE_DEF)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_pins_sck_i_ival,
    input  logic                  io_pins_cs_0_i_ival,
    input  logic                  io_pins_dq_0_i_ival,
    output logic                  io_pins_dq_1_o_oval,
    output logic                  io_pins_dq_1_o_oe,
    output logic                  io_pins_dq_1_o_ie,
    output logic                  io_pins_dq_1_o_pue,
    output logic                  io_pins_dq_1_o_ds,
    output logic                  io_rx_valid,
    input  logic                  io_rx_ready,
    output logic [FRAME_BITS-1:0] io_rx_bits,
    input  logic                  io_tx_valid,
    output logic                  io_tx_ready,
    input  logic [FRAME_BITS-1:0] io_tx_bits,
    output logic                  io_active,
    output logic                  io_rx_overrun,
    output logic                  io_tx_underrun,
    input  logic                  io_err_clr
);

    localparam int unsigned     CNT_W    = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    logic sck_sync, sck_edge_c;
    logic cs_sync, cs_edge_c;
    logic mosi_sync, mosi_edge_unused;

    spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clock(clock), .reset(reset), .din(io_pins_sck_i_ival),
        .sync(sck_sync), .edge_c(sck_edge_c)
    );

    spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clock(clock), .reset(reset), .din(io_pins_cs_0_i_ival),
        .sync(cs_sync), .edge_c(cs_edge_c)
    );

    spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clock(clock), .reset(reset), .din(io_pins_dq_0_i_ival),
        .sync(mosi_sync), .edge_c(mosi_edge_unused)
    );

    state_e                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   rx_shift;
    logic [FRAME_BITS-1:0]   tx_shift;
    logic [FRAME_BITS-1:0]   tx_hold;
    logic                    hold_empty;
    logic [FRAME_BITS-1:0]   rx_bits;
    logic                    rx_valid;
    logic                    rx_overrun;
    logic                    tx_underrun;
    logic                    miso_oe;
    logic                    miso_oval;
    logic                    active;

    logic                    frame_start_c, frame_end_c, sck_ok_c;
    logic                    load_c, shift_c, sample_c, word_done_c;
    logic                    rx_accept_c, tx_write_c, rx_consume_c;
    logic [FRAME_BITS-1:0]   tx_next_c, rx_next_c;

    // Event decode; a CS rise masks any SCK edge seen in the same cycle.
    always_comb begin
        frame_start_c = 1'b0;
        frame_end_c   = 1'b0;
        sck_ok_c      = 1'b0;
        load_c        = 1'b0;
        shift_c       = 1'b0;
        sample_c      = 1'b0;
        word_done_c   = 1'b0;
        rx_accept_c   = 1'b0;
        tx_next_c     = tx_shift;
        rx_next_c     = {rx_shift[FRAME_BITS-2:0], mosi_sync};
        tx_write_c    = io_tx_valid & hold_empty;
        rx_consume_c  = rx_valid & io_rx_ready;

        if (state == IDLE) begin
            frame_start_c = cs_edge_c & ~cs_sync;
        end else begin
            frame_end_c = cs_edge_c & cs_sync;
            sck_ok_c    = ~frame_end_c;
        end

        sample_c    = sck_ok_c & sck_edge_c & sck_sync;
        word_done_c = sample_c & (bit_cnt == CNT_LAST);
        rx_accept_c = word_done_c & (~rx_valid | io_rx_ready);
        load_c      = frame_start_c | (sck_ok_c & sck_edge_c & ~sck_sync & (bit_cnt == '0));
        shift_c     = sck_ok_c & sck_edge_c & ~sck_sync & (bit_cnt != '0);

        if (load_c) begin
            tx_next_c = hold_empty ? FILL_BYTE : tx_hold;
        end else if (shift_c) begin
            tx_next_c = {tx_shift[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_hold     <= '0;
            hold_empty  <= 1'b1;
            rx_bits     <= '0;
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_underrun <= 1'b0;
            miso_oe     <= 1'b0;
            miso_oval   <= 1'b0;
            active      <= 1'b0;
        end else begin
            tx_shift <= tx_next_c;

            if (frame_start_c) begin
                state     <= SHIFT;
                active    <= 1'b1;
                miso_oe   <= 1'b1;
                miso_oval <= tx_next_c[FRAME_BITS-1];
                bit_cnt   <= '0;
            end else if (frame_end_c) begin
                state     <= IDLE;
                active    <= 1'b0;
                miso_oe   <= 1'b0;
                miso_oval <= 1'b0;
                bit_cnt   <= '0;
            end else if (state == SHIFT) begin
                miso_oval <= tx_next_c[FRAME_BITS-1];
                if (sample_c) begin
                    rx_shift <= rx_next_c;
                    bit_cnt  <= word_done_c ? '0 : bit_cnt + CNT_W'(1);
                end
            end

            // RX holding register handshake
            if (rx_accept_c) begin
                rx_bits  <= rx_next_c;
                rx_valid <= 1'b1;
            end else if (rx_consume_c) begin
                rx_valid <= 1'b0;
            end

            // A load empties the holding register; a same-cycle write refills it.
            if (load_c && !hold_empty) begin
                hold_empty <= 1'b1;
            end
            if (tx_write_c) begin
                tx_hold    <= io_tx_bits;
                hold_empty <= 1'b0;
            end

            if (io_err_clr) begin
                rx_overrun  <= 1'b0;
                tx_underrun <= 1'b0;
            end
            if (word_done_c && !rx_accept_c) begin
                rx_overrun <= 1'b1;
            end
            if (load_c && hold_empty) begin
                tx_underrun <= 1'b1;
            end
        end
    end

    assign io_pins_dq_1_o_oval = miso_oval;
    assign io_pins_dq_1_o_oe   = miso_oe;
    assign io_pins_dq_1_o_ie   = 1'b0;
    assign io_pins_dq_1_o_pue  = 1'b0;
    assign io_pins_dq_1_o_ds   = 1'b1;
    assign io_rx_valid         = rx_valid;
    assign io_rx_bits          = rx_bits;
    assign io_tx_ready         = hold_empty;
    assign io_active           = active;
    assign io_rx_overrun       = rx_overrun;
    assign io_tx_underrun      = tx_underrun;

endmodule

// File: tb/tb_spi_slave_port.sv
// Self-checking bench: acts as a mode-0 SPI master and compares against a word-level model.
module tb_spi_slave_port;

    localparam int unsigned SS = 3;
    localparam int unsigned FB = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sck   = 1'b0;
    logic          cs    = 1'b1;
    logic          mosi  = 1'b0;
    logic          miso_oval, miso_oe, miso_ie, miso_pue, miso_ds;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [FB-1:0] rx_bits;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [FB-1:0] tx_bits = '0;
    logic          active, rx_overrun, tx_underrun;
    logic          err_clr = 1'b0;

    always #5 clock = ~clock;

    spi_slave_port #(.SYNC_STAGES(SS), .FRAME_BITS(FB), .FILL_BYTE(8'hFF)) dut (
        .clock(clock), .reset(reset),
        .io_pins_sck_i_ival(sck), .io_pins_cs_0_i_ival(cs), .io_pins_dq_0_i_ival(mosi),
        .io_pins_dq_1_o_oval(miso_oval), .io_pins_dq_1_o_oe(miso_oe),
        .io_pins_dq_1_o_ie(miso_ie), .io_pins_dq_1_o_pue(miso_pue), .io_pins_dq_1_o_ds(miso_ds),
        .io_rx_valid(rx_valid), .io_rx_ready(rx_ready), .io_rx_bits(rx_bits),
        .io_tx_valid(tx_valid), .io_tx_ready(tx_ready), .io_tx_bits(tx_bits),
        .io_active(active), .io_rx_overrun(rx_overrun), .io_tx_underrun(tx_underrun),
        .io_err_clr(err_clr)
    );

    int checks = 0;
    int errors = 0;

    // Word-level model of the responder
    logic [FB-1:0] hold_q[$];
    logic [FB-1:0] cur_tx;
    bit            m_und, m_ovr, m_rxv;
    logic [FB-1:0] m_rxb;
    bit            mid_wr_en;
    logic [FB-1:0] mid_wr_val;
    logic [FB-1:0] mi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic model_load();
        if (hold_q.size() > 0) begin
            cur_tx = hold_q.pop_front();
        end else begin
            cur_tx = 8'hFF;
            m_und  = 1'b1;
        end
    endtask

    task automatic tx_write(input logic [FB-1:0] b);
        check("tx_ready_pre_write", 32'(tx_ready), 32'(hold_q.size() == 0));
        tx_valid = 1'b1;
        tx_bits  = b;
        tick(1);
        tx_valid = 1'b0;
        hold_q.push_back(b);
        check("tx_ready_post_write", 32'(tx_ready), 32'd0);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        model_load();
        tick(8);
        check("oe_frame_start", 32'(miso_oe), 32'd1);
        check("active_frame_start", 32'(active), 32'd1);
        check("tx_ready_frame_start", 32'(tx_ready), 32'(hold_q.size() == 0));
    endtask

    task automatic cs_high();
        cs = 1'b1;
        tick(8);
        check("oe_frame_end", 32'(miso_oe), 32'd0);
        check("active_frame_end", 32'(active), 32'd0);
    endtask

    // One word (or a partial word) of SCK cycles, 16 clocks per bit.
    task automatic xfer_word(input logic [FB-1:0] mo, input int nbits, input bit lat_chk,
                             output logic [FB-1:0] mo_seen);
        mo_seen = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[FB-1-i];
            tick(8);
            sck = 1'b1;
            mo_seen[FB-1-i] = miso_oval;
            check("miso_bit", 32'(miso_oval), 32'(cur_tx[FB-1-i]));
            if (lat_chk && i == nbits - 1) begin
                tick(SS);
                check("rx_valid_latency_early", 32'(rx_valid), 32'd0);
                tick(1);
                check("rx_valid_latency_rise", 32'(rx_valid), 32'd1);
                tick(8 - SS - 1);
            end else begin
                tick(8);
            end
            sck = 1'b0;
            if (mid_wr_en && i == 3) begin
                tx_write(mid_wr_val);
                mid_wr_en = 1'b0;
            end
        end
        mid_wr_en = 1'b0;
        tick(8);
        if (nbits == FB) begin
            if (!m_rxv) begin
                m_rxv = 1'b1;
                m_rxb = mo;
            end else begin
                m_ovr = 1'b1;
            end
            model_load();
        end
    endtask

    task automatic consume();
        check("rx_valid_state", 32'(rx_valid), 32'(m_rxv));
        if (m_rxv) begin
            check("rx_bits", 32'(rx_bits), 32'(m_rxb));
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
            m_rxv = 1'b0;
            check("rx_valid_after_consume", 32'(rx_valid), 32'd0);
        end
    endtask

    task automatic check_flags();
        check("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
        check("tx_underrun", 32'(tx_underrun), 32'(m_und));
        check("tx_ready", 32'(tx_ready), 32'(hold_q.size() == 0));
    endtask

    task automatic do_err_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_ovr = 1'b0;
        m_und = 1'b0;
        check_flags();
    endtask

    initial begin
        // 1: reset state with CS high
        tick(3);
        reset = 1'b0;
        tick(8);
        check("reset_oe", 32'(miso_oe), 32'd0);
        check("reset_oval", 32'(miso_oval), 32'd0);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_active", 32'(active), 32'd0);
        check("pad_consts", 32'({miso_ie, miso_pue, miso_ds}), 32'b001);
        check_flags();

        // 2: preloaded A5 out, 3C in, with rx_valid latency
        tx_write(8'hA5);
        cs_low();
        xfer_word(8'h3C, FB, 1'b1, mi);
        check("miso_word_a5", 32'(mi), 32'hA5);
        check("rx_bits_3c", 32'(rx_bits), 32'h3C);
        consume();
        cs_high();
        check_flags();

        // 3: back-to-back words without consuming -> overrun, then clear
        cs_low();
        xfer_word(8'h11, FB, 1'b0, mi);
        xfer_word(8'h22, FB, 1'b0, mi);
        cs_high();
        check("rx_bits_held_11", 32'(rx_bits), 32'h11);
        check("overrun_set", 32'(rx_overrun), 32'd1);
        check_flags();
        consume();
        do_err_clr();
        check("overrun_cleared", 32'(rx_overrun), 32'd0);

        // 4: nothing queued -> fill word; a mid-word write lands at the next boundary
        cs_low();
        check("underrun_at_start", 32'(tx_underrun), 32'd1);
        mid_wr_en  = 1'b1;
        mid_wr_val = 8'h5A;
        xfer_word(8'h00, FB, 1'b0, mi);
        check("miso_fill", 32'(mi), 32'hFF);
        consume();
        xfer_word(8'hF0, FB, 1'b0, mi);
        check("miso_midword_load", 32'(mi), 32'h5A);
        consume();
        cs_high();
        check_flags();
        do_err_clr();

        // 5: frame aborted after 5 bits; queued TX survives; next frame works
        cs_low();
        mid_wr_en  = 1'b1;
        mid_wr_val = 8'hC3;
        xfer_word(8'hE7, 5, 1'b0, mi);
        cs_high();
        check("abort_no_rx_valid", 32'(rx_valid), 32'd0);
        check("abort_oe", 32'(miso_oe), 32'd0);
        check_flags();
        cs_low();
        xfer_word(8'h81, FB, 1'b0, mi);
        check("miso_kept_c3", 32'(mi), 32'hC3);
        check("rx_bits_81", 32'(rx_bits), 32'h81);
        consume();
        cs_high();
        check_flags();

        // 6: reset in the middle of a word
        tx_write(8'h96);
        cs_low();
        xfer_word(8'hAA, 3, 1'b0, mi);
        reset = 1'b1;
        tick(1);
        check("midreset_rx_valid", 32'(rx_valid), 32'd0);
        check("midreset_tx_ready", 32'(tx_ready), 32'd1);
        check("midreset_active", 32'(active), 32'd0);
        check("midreset_oe", 32'(miso_oe), 32'd0);
        check("midreset_oval", 32'(miso_oval), 32'd0);
        check("midreset_flags", 32'({rx_overrun, tx_underrun}), 32'd0);
        hold_q.delete();
        m_und = 1'b0;
        m_ovr = 1'b0;
        m_rxv = 1'b0;
        cs  = 1'b1;
        sck = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(8);
        check("post_reset_active", 32'(active), 32'd0);
        check_flags();

        // Randomized frames against the model
        for (int f = 0; f < 8; f++) begin
            int nw;
            if ($urandom_range(1, 0) == 1) tx_write(8'($urandom));
            cs_low();
            nw = int'($urandom_range(3, 1));
            for (int w = 0; w < nw; w++) begin
                mid_wr_en  = (hold_q.size() == 0) && ($urandom_range(1, 0) == 1);
                mid_wr_val = 8'($urandom);
                xfer_word(8'($urandom), FB, 1'b0, mi);
                if ($urandom_range(1, 0) == 1) consume();
                check_flags();
            end
            if ($urandom_range(3, 0) == 0) xfer_word(8'($urandom), int'($urandom_range(7, 1)), 1'b0, mi);
            cs_high();
            check_flags();
            if ($urandom_range(2, 0) == 0) do_err_clr();
            if ($urandom_range(1, 0) == 1) consume();
        end
        consume();
        check_flags();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
